data_gen_stream: RTL

DATA_GEN_STREAM -- requirements
Module: data_gen_stream

---
 rtl/data_gen_pkg.sv | 22 ++
 rtl/data_gen_stream_if.sv | 29 ++
 rtl/data_gen_stream_pattern_next.sv | 25 ++
 rtl/data_gen_stream.sv | 114 +++++++++++
 4 files changed

// File: rtl/data_gen_pkg.sv
// Shared types for the data_gen_stream pattern generator.
package data_gen_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    // Pattern select, captured when a burst starts
    typedef enum logic [MODE_W-1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    // Burst controller states
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/data_gen_stream_if.sv
// Control and valid/ready stream bundle between the generator and its user.
interface data_gen_stream_if
    import data_gen_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_LEN_WIDTH  = 8
);
    logic                    start;
    logic [MODE_W-1:0]       mode;
    logic [P_LEN_WIDTH-1:0]  burst_len;
    logic [P_DATA_WIDTH-1:0] seed;
    logic                    ready;
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    busy;
    logic                    done;

    // Generator side: sources the stream, takes burst requests
    modport master (
        input  start, mode, burst_len, seed, ready,
        output valid, data, busy, done
    );

    // User side: issues bursts, sinks the stream
    modport slave (
        output start, mode, burst_len, seed, ready,
        input  valid, data, busy, done
    );
endinterface

// File: rtl/data_gen_stream_pattern_next.sv
// Combinational next-word function for the four pattern modes.
module pattern_next
    import data_gen_pkg::*;
#(
    parameter int unsigned             P_DATA_WIDTH = 8,
    parameter logic [P_DATA_WIDTH-1:0] P_LFSR_POLY  = P_DATA_WIDTH'(8'hB8)
) (
    input  mode_e                   mode_i,
    input  logic [P_DATA_WIDTH-1:0] word_i,
    output logic [P_DATA_WIDTH-1:0] next_o
);

    // Select the successor of the current word
    always_comb begin
        next_o = word_i;
        case (mode_i)
            MODE_CNT:   next_o = word_i + P_DATA_WIDTH'(1);
            MODE_LFSR:  next_o = (word_i >> 1) ^ (word_i[0] ? P_LFSR_POLY : '0);
            MODE_WALK:  next_o = {word_i[P_DATA_WIDTH-2:0], word_i[P_DATA_WIDTH-1]};
            MODE_CONST: next_o = word_i;
            default:    next_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_gen_stream.sv
// Burst pattern generator: on start, streams burst_len words over valid/ready.
module data_gen_stream
    import data_gen_pkg::*;
#(
    parameter int unsigned             P_DATA_WIDTH = 8,
    parameter int unsigned             P_LEN_WIDTH  = 8,
    parameter logic [P_DATA_WIDTH-1:0] P_LFSR_POLY  = P_DATA_WIDTH'(8'hB8)
) (
    input  logic              clk_100,
    input  logic              s_rst,
    data_gen_stream_if.master bus
);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [P_LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [P_DATA_WIDTH-1:0] next_word;
    logic [P_DATA_WIDTH-1:0] seed_eff;
    mode_e                   mode_in;

    assign mode_in  = mode_e'(bus.mode);
    // An all-zero LFSR seed would lock up, so it is promoted to 1
    assign seed_eff = (mode_in == MODE_LFSR && bus.seed == '0) ? P_DATA_WIDTH'(1) : bus.seed;

    pattern_next #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_LFSR_POLY  (P_LFSR_POLY)
    ) u_pattern_next (
        .mode_i (mode_q),
        .word_i (data_q),
        .next_o (next_word)
    );

    // State and output registers with synchronous reset
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_CNT;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.burst_len != '0) begin
                        mode_d  = mode_in;
                        cnt_d   = bus.burst_len;
                        data_d  = seed_eff;
                        valid_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            SEND: begin
                if (valid_q && bus.ready) begin
                    cnt_d = cnt_q - P_LEN_WIDTH'(1);
                    if (cnt_q == P_LEN_WIDTH'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        data_d = next_word;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.valid = valid_q;
    assign bus.data  = data_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
